// File: rtl/mc_path_if.sv
// mc_path_if: valid/ready path-word stream from the generator to the pricing core.
// The master side owns everything except out_ready.
interface mc_path_if #(
  parameter int W  = 12,
  parameter int DW = 3,
  parameter int IW = 7
);
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  path;
  logic [DW-1:0] out_day;
  logic [IW-1:0] out_idx;
  logic          out_last;

  modport master (
    output out_valid, path, out_day, out_idx, out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid, path, out_day, out_idx, out_last,
    output out_ready
  );
endinterface

// File: rtl/mc_path_gen.sv
// mc_path_gen: binomial Monte Carlo path builder, streamed backward in time.
// Optional macro ANTITHETIC_EN mirrors each even path's steps onto the next path.
module mc_path_gen #(
  parameter int N   = 128,
  parameter int DAY = 8,
  parameter int W   = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] s0,
  input  logic [11:0]  up,
  input  logic [11:0]  dn,
  input  logic [15:0]  seed,
  output logic         busy,
  output logic         done,
  mc_path_if.master    o
);
  localparam int IW = $clog2(N);
  localparam int DW = $clog2(DAY);
  localparam int AW = IW + DW;
  localparam logic [IW-1:0] ILAST = IW'(N - 1);
  localparam logic [DW-1:0] DLAST = DW'(DAY - 1);
  localparam logic [DW-1:0] DONE1 = DW'(1);

  typedef enum logic [1:0] {IDLE, GEN, STRM} state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [W-1:0]  s0_q, s0_d;
  logic [11:0]   up_q, up_d;
  logic [11:0]   dn_q, dn_d;
  logic [IW-1:0] gp_q, gp_d;
  logic [DW-1:0] gd_q, gd_d;
  logic          vld_q, vld_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic [W-1:0]  path_q, path_d;
  logic [DW-1:0] day_q, day_d;
  logic [IW-1:0] idx_q, idx_d;

  logic [W-1:0]  mem [N*DAY];
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  prev;
  logic [W-1:0]  nxt;
  logic [11:0]   fac;
  logic [W+11:0] prod;
  logic          step_bit;
  logic [15:0]   lfsr_adv;
  logic [DW-1:0] nday;
  logic [IW-1:0] nidx;

`ifdef ANTITHETIC_EN
  logic [DAY-1:1] hist_q, hist_d;
`endif

  assign lfsr_adv = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5],
                     lfsr_q[15:1]};

`ifdef ANTITHETIC_EN
  assign step_bit = gp_q[0] ? ~hist_q[gd_q] : lfsr_q[0];
`else
  assign step_bit = lfsr_q[0];
`endif

  assign prev = (gd_q == DONE1) ? s0_q : mem[{gd_q - DONE1, gp_q}];
  assign fac  = step_bit ? up_q : dn_q;
  assign prod = {12'd0, prev} * {{W{1'b0}}, fac};
  // Q2.10 scaling: anything above the W integer bits saturates
  assign nxt  = (|prod[W+11:W+10]) ? {W{1'b1}} : prod[W+9:10];

  assign wr_addr = {gd_q, gp_q};
  assign nidx    = last_q ? '0 : idx_q + IW'(1);
  assign nday    = last_q ? day_q - DONE1 : day_q;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    s0_d    = s0_q;
    up_d    = up_q;
    dn_d    = dn_q;
    gp_d    = gp_q;
    gd_d    = gd_q;
    vld_d   = vld_q;
    last_d  = last_q;
    done_d  = 1'b0;
    path_d  = path_q;
    day_d   = day_q;
    idx_d   = idx_q;
    wr_en   = 1'b0;
`ifdef ANTITHETIC_EN
    hist_d  = hist_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start && !done_q) begin
          s0_d    = s0;
          up_d    = up;
          dn_d    = dn;
          lfsr_d  = (seed == 16'd0) ? 16'hACE1 : seed;
          gp_d    = '0;
          gd_d    = DONE1;
          state_d = GEN;
        end
      end
      GEN: begin
        wr_en = 1'b1;
`ifdef ANTITHETIC_EN
        if (!gp_q[0]) begin
          lfsr_d         = lfsr_adv;
          hist_d[gd_q]   = lfsr_q[0];
        end
`else
        lfsr_d = lfsr_adv;
`endif
        if (gd_q == DLAST) begin
          gd_d = DONE1;
          gp_d = gp_q + IW'(1);
          if (gp_q == ILAST) begin
            // first word is already in the buffer, present it immediately
            state_d = STRM;
            vld_d   = 1'b1;
            path_d  = mem[{DLAST, {IW{1'b0}}}];
            day_d   = DLAST;
            idx_d   = '0;
            last_d  = (N == 1);
          end
        end else begin
          gd_d = gd_q + DONE1;
        end
      end
      STRM: begin
        if (vld_q && o.out_ready) begin
          if (day_q == DONE1 && last_q) begin
            vld_d   = 1'b0;
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            path_d = mem[{nday, nidx}];
            day_d  = nday;
            idx_d  = nidx;
            last_d = (nidx == ILAST);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lfsr_q  <= 16'hACE1;
      s0_q    <= '0;
      up_q    <= '0;
      dn_q    <= '0;
      gp_q    <= '0;
      gd_q    <= '0;
      vld_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      path_q  <= '0;
      day_q   <= '0;
      idx_q   <= '0;
`ifdef ANTITHETIC_EN
      hist_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      s0_q    <= s0_d;
      up_q    <= up_d;
      dn_q    <= dn_d;
      gp_q    <= gp_d;
      gd_q    <= gd_d;
      vld_q   <= vld_d;
      last_q  <= last_d;
      done_q  <= done_d;
      path_q  <= path_d;
      day_q   <= day_d;
      idx_q   <= idx_d;
`ifdef ANTITHETIC_EN
      hist_q  <= hist_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = done_q;
  assign o.out_valid = vld_q;
  assign o.path      = path_q;
  assign o.out_day   = day_q;
  assign o.out_idx   = idx_q;
  assign o.out_last  = last_q;
endmodule

// File: doc/mc_path_gen.md
Name: mc_path_gen

Overview:
Monte Carlo path generator and streamer on the producer side of the pricing core's path input.
- Builds N binomial-step price paths of DAY days from a spot price and up/down factors, using an LFSR as the random source.
- Buffers all paths, then streams them backward in time: day DAY-1 down to day 1, paths 0..N-1 within each day. This is the order a backward-induction pricing core consumes.
- Uses a valid/ready handshake so the consumer can stall it.

Parameters:
N, 128, number of simulated paths
DAY, 8, days per path including day 0 (spot); days 1..DAY-1 are stored and streamed
W, 12, price width in bits

Ports:
clk  input  1  clock
rst_n  input  1  reset, asynchronous, active-low
start  input  1  one-cycle pulse; begins generation when idle
s0  input  W  spot price at day 0; sampled on the accepted start
up  input  12  up factor, unsigned Q2.10 (1024 = 1.0); sampled on start
dn  input  12  down factor, unsigned Q2.10; sampled on start
seed  input  16  LFSR seed; sampled on start
busy  output  1  high from the accepted start until done
out_valid  output  1  path word valid
out_ready  input  1  consumer accepts word
path  output  W  price of path out_idx on day out_day
out_day  output  3  day index of the current word
out_idx  output  7  path index of the current word
out_last  output  1  high on the last path (idx N-1) of each day block
done  output  1  one-cycle pulse after the final word is accepted

Behaviour:
- Reset: state IDLE; LFSR = 16'hACE1.
  - busy, out_valid, out_last and done are 0.
  - path, out_day and out_idx are 0.
  - Buffer contents are don't-care.
- Reset mid-operation aborts immediately. No partial stream resumes after reset.
- IDLE:
  - start=1 latches s0, up, dn and seed.
  - LFSR loads seed; a seed of 0 loads 16'hACE1 instead.
  - Sets busy=1 and moves to GEN.
  - start while busy is ignored.
- GEN: one step per cycle, path-major order (p=0..N-1, d=1..DAY-1), N*(DAY-1) cycles total (896 at the defaults).
  - prev = s0 when d=1, otherwise the stored price of (p, d-1).
  - f = up if LFSR bit0 = 1, else dn.
  - prod = prev*f, 24 bits.
  - next = 4095 if prod[23:22] != 0, else prod[21:10]. This truncates and saturates.
  - next is stored at buffer[d*N+p].
  - LFSR is Fibonacci x^16+x^14+x^13+x^11+1 and advances every GEN cycle.
  - A price of 0 stays 0.
- STREAM: entered on the cycle after the last GEN write.
  - The output register loads buffer[day*N+idx] when out_valid=0 or (out_valid & out_ready).
  - The first word (day DAY-1, idx 0) is valid on the first STREAM cycle.
  - Throughput is one word per cycle when out_ready stays high.
  - While out_valid=1 and out_ready=0, path, out_day, out_idx and out_last hold stable.
  - idx increments from 0 to N-1. It then wraps to 0 and day decrements.
  - out_last=1 when idx=N-1.
- Final word is (day 1, idx N-1). On its handshake:
  - out_valid drops the next cycle.
  - done pulses one cycle.
  - busy drops with done.
  - State returns to IDLE.
- A start arriving in the same cycle as done is ignored.
- The total stream is N*(DAY-1) words.

Optional Feature:
ANTITHETIC_EN:
- Defined:
  - Paths are paired (2k, 2k+1).
  - The even path uses LFSR bits as above. Its DAY-1 step bits are kept in a shift register.
  - The odd path uses the inverted stored bit for each day. The LFSR does not advance during odd-path steps.
  - GEN cycle count is unchanged.
- Undefined:
  - Every path draws fresh LFSR bits.
  - No bit-history register exists.

Test Plan:
- up=dn=1024, s0=1024, any seed → 896 words, all path=1024, order (day7 idx0..127), …, (day1 idx0..127); out_last on every idx 127; one done pulse; busy low afterward.
- s0=4000, up=dn=2048 → every word = 4095 (saturation); s0=0 → every word = 0.
- up=1126, dn=922, s0=1024, seed=1 → day-1 words are exactly 1126 or 922, matching a reference LFSR model bit-for-bit; seed=0 gives the same stream as seed=16'hACE1.
- Constant case, out_ready held low 5 cycles at word (day5, idx 40) → path/out_day/out_idx stable for those cycles; no word lost or duplicated across the full count.
- rst_n asserted during STREAM at (day3, idx 10) → out_valid, busy, done = 0 immediately; a new start then produces the full 896-word stream from day 7.
- ANTITHETIC_EN, up=1126, dn=922, s0=1024 → for every k, day-1 value of path 2k+1 is the opposite factor result of path 2k (1126 ↔ 922).
